// File: rtl/pc_ras_pkg.sv
// Shared types for the Nibbler program counter with return-address stack.
// Command encoding and priority resolution live here.
package pc_pkg;

  localparam int AW = 12;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_INC,
    CMD_LOAD,
    CMD_CALL,
    CMD_RET
  } cmd_e;

  function automatic cmd_e prio_cmd(
    input logic ret,
    input logic call,
    input logic load,
    input logic inc
  );
    if (ret)       return CMD_RET;
    else if (call) return CMD_CALL;
    else if (load) return CMD_LOAD;
    else if (inc)  return CMD_INC;
    else           return CMD_NONE;
  endfunction

endpackage

// File: rtl/pc_ras_if.sv
// Decoder-to-PC bundle: commands and target in, ROM address and
// stack status out.
interface pc_ras_if #(
  parameter int AW    = 12,
  parameter int DEPTH = 4
);
  localparam int DW = $clog2(DEPTH + 1);

  logic [AW-1:0] newaddr;
  logic          loadPC;
  logic          incPC;
  logic          callPC;
  logic          retPC;
  logic [AW-1:0] addr;
  logic [DW-1:0] depth;
  logic          full;
  logic          empty;
  logic          ovf;
  logic          unf;
  logic          trap;

  modport master (
    output newaddr, loadPC, incPC, callPC, retPC,
    input  addr, depth, full, empty, ovf, unf, trap
  );

  modport slave (
    input  newaddr, loadPC, incPC, callPC, retPC,
    output addr, depth, full, empty, ovf, unf, trap
  );
endinterface

// File: rtl/pc_ras_ret_stack.sv
// Circular return-address LIFO; a push while full overwrites the
// oldest entry and pulses ovf, a pop while empty pulses unf.
module ret_stack #(
  parameter int AW    = 12,
  parameter int DEPTH = 4,
  localparam int DW   = $clog2(DEPTH + 1),
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] wdata,
  output logic [AW-1:0] rdata,
  output logic [DW-1:0] depth,
  output logic          ovf,
  output logic          unf
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [DW-1:0] FULL = DW'(DEPTH);

  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] top;
  logic [PW-1:0] top_nx;
  logic [PW-1:0] top_pv;

  assign top_nx = (top == LAST) ? '0 : top + 1'b1;
  assign top_pv = (top == '0) ? LAST : top - 1'b1;
  assign rdata  = mem[top_pv];

  always_ff @(posedge clk) begin
    if (rst) begin
      top   <= '0;
      depth <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      ovf <= 1'b0;
      unf <= 1'b0;
      if (push) begin
        mem[top] <= wdata;
        top      <= top_nx;
        if (depth == FULL) ovf <= 1'b1;
        else depth <= depth + 1'b1;
      end else if (pop) begin
        if (depth == '0) begin
          unf <= 1'b1;
        end else begin
          top   <= top_pv;
          depth <= depth - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pc_ras.sv
// Nibbler program counter with hardware return-address stack.
// Optional sticky wrap trap on increment: define PC_WRAP_TRAP_EN.
module pc_ras #(
  parameter int            AW         = 12,
  parameter int            DEPTH      = 4,
  parameter logic [AW-1:0] RESET_ADDR = '0
) (
  input logic     clk,
  input logic     Rst,
  pc_ras_if.slave bus
);
  import pc_pkg::*;

  localparam int            DW   = $clog2(DEPTH + 1);
  localparam logic [DW-1:0] FULL = DW'(DEPTH);

  cmd_e          cmd;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] rdata;
  logic [DW-1:0] depth;

  assign cmd = prio_cmd(bus.retPC, bus.callPC,
                        bus.loadPC, bus.incPC);

  ret_stack #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst   (Rst),
    .push  (cmd == CMD_CALL),
    .pop   (cmd == CMD_RET),
    .wdata (addr_q + 1'b1),
    .rdata (rdata),
    .depth (depth),
    .ovf   (bus.ovf),
    .unf   (bus.unf)
  );

`ifdef PC_WRAP_TRAP_EN
  logic trap_q;
  assign bus.trap = trap_q;
`else
  assign bus.trap = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (Rst) begin
      addr_q <= RESET_ADDR;
`ifdef PC_WRAP_TRAP_EN
      trap_q <= 1'b0;
`endif
    end else begin
      unique case (cmd)
        CMD_RET:  if (depth != '0) addr_q <= rdata;
        CMD_CALL: addr_q <= bus.newaddr;
        CMD_LOAD: addr_q <= bus.newaddr;
        CMD_INC: begin
`ifdef PC_WRAP_TRAP_EN
          if (!trap_q) begin
            if (&addr_q) trap_q <= 1'b1;
            else addr_q <= addr_q + 1'b1;
          end
`else
          addr_q <= addr_q + 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.addr  = addr_q;
  assign bus.depth = depth;
  assign bus.full  = (depth == FULL);
  assign bus.empty = (depth == '0);

endmodule

// File: tb/tb_pc_ras.sv
// Directed plus random checks of pc_ras against a queue-based model.
// Build with PC_WRAP_TRAP_EN to exercise the trap variant.
module tb_pc_ras;

  localparam int AW    = 12;
  localparam int DEPTH = 4;
  localparam int MASK  = (1 << AW) - 1;

  logic clk = 1'b0;
  logic Rst = 1'b0;

  pc_ras_if #(.AW(AW), .DEPTH(DEPTH)) bus ();

  pc_ras #(
    .AW         (AW),
    .DEPTH      (DEPTH),
    .RESET_ADDR ('0)
  ) dut (
    .clk (clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int m_addr = 0;
  int m_q[$];
  bit m_ovf = 0;
  bit m_unf = 0;
  bit m_trap = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit r, input bit ret, input bit call,
                       input bit load, input bit inc, input int na);
    m_ovf = 0;
    m_unf = 0;
    if (r) begin
      m_addr = 0;
      m_q.delete();
      m_trap = 0;
    end else if (ret) begin
      if (m_q.size() > 0) m_addr = m_q.pop_back();
      else m_unf = 1;
    end else if (call) begin
      m_q.push_back((m_addr + 1) & MASK);
      if (m_q.size() > DEPTH) begin
        void'(m_q.pop_front());
        m_ovf = 1;
      end
      m_addr = na;
    end else if (load) begin
      m_addr = na;
    end else if (inc) begin
`ifdef PC_WRAP_TRAP_EN
      if (!m_trap) begin
        if (m_addr == MASK) m_trap = 1;
        else m_addr = m_addr + 1;
      end
`else
      m_addr = (m_addr + 1) & MASK;
`endif
    end
  endtask

  task automatic step(input bit r, input bit ret, input bit call,
                      input bit load, input bit inc, input int na);
    @(negedge clk);
    Rst          = r;
    bus.retPC    = ret;
    bus.callPC   = call;
    bus.loadPC   = load;
    bus.incPC    = inc;
    bus.newaddr  = AW'(na);
    @(posedge clk);
    model(r, ret, call, load, inc, na);
    #1;
    chk("addr",  32'(bus.addr),  32'(m_addr));
    chk("depth", 32'(bus.depth), 32'(m_q.size()));
    chk("full",  32'(bus.full),  32'(m_q.size() == DEPTH));
    chk("empty", 32'(bus.empty), 32'(m_q.size() == 0));
    chk("ovf",   32'(bus.ovf),   32'(m_ovf));
    chk("unf",   32'(bus.unf),   32'(m_unf));
    chk("trap",  32'(bus.trap),  32'(m_trap));
  endtask

  initial begin
    bus.newaddr = '0;
    bus.loadPC  = 1'b0;
    bus.incPC   = 1'b0;
    bus.callPC  = 1'b0;
    bus.retPC   = 1'b0;

    // 1: reset, then count up
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("rst_addr", 32'(bus.addr), 32'h0);
    for (int i = 1; i <= 5; i++) begin
      step(0, 0, 0, 0, 1, 0);
      chk("inc_seq", 32'(bus.addr), 32'(i));
    end

    // 2: load beats inc
    step(0, 0, 0, 1, 0, 'h003);
    step(0, 0, 0, 1, 1, 'h00D);
    chk("load_inc", 32'(bus.addr), 32'h00D);
    step(0, 0, 0, 0, 1, 0);
    chk("inc_after", 32'(bus.addr), 32'h00E);

    // 3: single call / return
    step(0, 0, 0, 1, 0, 'h010);
    step(0, 0, 1, 0, 0, 'h200);
    chk("call1", 32'(bus.addr), 32'h200);
    step(0, 0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("ret1", 32'(bus.addr), 32'h011);

    // 4: overflow then full unwind
    step(0, 0, 0, 1, 0, 'h001);
    for (int i = 1; i <= 5; i++) begin
      step(0, 0, 1, 0, 0, i * 'h100);
      if (i < 5) step(0, 0, 0, 0, 1, 0);
    end
    chk("ovf5", 32'(bus.ovf), 32'h1);
    step(0, 1, 0, 0, 0, 0);
    chk("ovf_clr", 32'(bus.ovf), 32'h0);
    chk("ret_a", 32'(bus.addr), 32'h402);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("ret_d", 32'(bus.addr), 32'h102);
    step(0, 1, 0, 0, 0, 0);
    chk("unf_hold", 32'(bus.addr), 32'h102);
    chk("unf5", 32'(bus.unf), 32'h1);

    // 5: increment at all-ones
    step(0, 0, 0, 1, 0, 'hFFF);
    step(0, 0, 0, 0, 1, 0);
`ifdef PC_WRAP_TRAP_EN
    chk("trap_set", 32'(bus.trap), 32'h1);
    chk("trap_addr", 32'(bus.addr), 32'hFFF);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 'h020);
    chk("trap_load", 32'(bus.addr), 32'h020);
    chk("trap_stk", 32'(bus.trap), 32'h1);
`else
    chk("wrap", 32'(bus.addr), 32'h000);
`endif

    // 6: reset overrides call
    step(0, 0, 1, 0, 0, 'h100);
    step(0, 0, 1, 0, 0, 'h200);
    step(0, 0, 1, 0, 0, 'h300);
    step(1, 0, 1, 0, 0, 'h400);
    chk("rst_call_d", 32'(bus.depth), 32'h0);
    step(0, 1, 0, 0, 0, 0);
    chk("rst_ret_u", 32'(bus.unf), 32'h1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(31) == 0),
           ($urandom_range(3) == 0),
           ($urandom_range(3) == 0),
           ($urandom_range(3) == 0),
           ($urandom_range(1) == 0),
           int'($urandom_range(MASK)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
